// File: rtl/wb_tracer_pkg.sv
// Shared constants for the Wishbone tracer: record field layout and overflow counter.
// Record layout, MSB to LSB: {ts, chan, we, adr, dat}.
package wb_tracer_pkg;

    localparam int unsigned CHAN_W = 3;
    localparam int unsigned WE_W   = 1;
    localparam int unsigned OVF_W  = 16;
    localparam logic [OVF_W-1:0] OVF_MAX = '1;

    function automatic int unsigned rec_width(input int unsigned ts_w,
                                              input int unsigned adr_w,
                                              input int unsigned dat_w);
        return ts_w + CHAN_W + WE_W + adr_w + dat_w;
    endfunction

    function automatic int unsigned adr_lsb(input int unsigned dat_w);
        return dat_w;
    endfunction

    function automatic int unsigned we_lsb(input int unsigned adr_w, input int unsigned dat_w);
        return dat_w + adr_w;
    endfunction

    function automatic int unsigned chan_lsb(input int unsigned adr_w, input int unsigned dat_w);
        return dat_w + adr_w + WE_W;
    endfunction

    function automatic int unsigned ts_lsb(input int unsigned adr_w, input int unsigned dat_w);
        return dat_w + adr_w + WE_W + CHAN_W;
    endfunction

endpackage

// File: rtl/wb_tracer_if.sv
// Bus bundle between the tracer and its environment: monitored channels plus FIFO read side.
interface wb_tracer_if #(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned ADR_WIDTH = 32,
    parameter int unsigned DAT_WIDTH = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned TS_WIDTH  = 16
);

    localparam int unsigned REC_W = wb_tracer_pkg::rec_width(TS_WIDTH, ADR_WIDTH, DAT_WIDTH);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic                            enable;
    logic                            clear;
    logic [CHANNELS-1:0]             ch_ack;
    logic [CHANNELS-1:0]             ch_we;
    logic [CHANNELS*ADR_WIDTH-1:0]   ch_adr;
    logic [CHANNELS*DAT_WIDTH-1:0]   ch_dat;
    logic [REC_W-1:0]                rd_data;
    logic                            rd_valid;
    logic                            rd_ack;
    logic [LVL_W-1:0]                level;
    logic [wb_tracer_pkg::OVF_W-1:0] ovf_cnt;

    modport master (
        output enable, clear, ch_ack, ch_we, ch_adr, ch_dat, rd_ack,
        input  rd_data, rd_valid, level, ovf_cnt
    );

    modport slave (
        input  enable, clear, ch_ack, ch_we, ch_adr, ch_dat, rd_ack,
        output rd_data, rd_valid, level, ovf_cnt
    );

endinterface

// File: rtl/trace_fifo.sv
// Circular trace FIFO with registered pointers and occupancy; head is zero while empty.
module trace_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign valid_o   = (level_q != '0);
    assign full_o    = (level_q == FULL_LVL);
    assign level_o   = level_q;
    assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;

    // A push into a full FIFO is allowed only when the head leaves on the same edge.
    assign do_pop  = rd_en_i & valid_o & ~clear_i;
    assign do_push = wr_en_i & (~full_o | do_pop) & ~clear_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
            else if (!do_push && do_pop) level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/wb_tracer.sv
// Wishbone transaction tracer: per-channel holding registers, fixed-priority drain into a
// timestamped trace FIFO, and a saturating count of transactions dropped on contention.
module wb_tracer
    import wb_tracer_pkg::*;
#(
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned ADR_WIDTH = 32,
    parameter int unsigned DAT_WIDTH = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned TS_WIDTH  = 16
) (
    input  logic       clk,
    input  logic       reset,
    wb_tracer_if.slave bus
);

    localparam int unsigned REC_W     = rec_width(TS_WIDTH, ADR_WIDTH, DAT_WIDTH);
    localparam int unsigned LVL_W     = $clog2(DEPTH) + 1;
    localparam int unsigned ADR_LSB   = adr_lsb(DAT_WIDTH);
    localparam int unsigned WE_LSB    = we_lsb(ADR_WIDTH, DAT_WIDTH);
    localparam int unsigned CHAN_LSB  = chan_lsb(ADR_WIDTH, DAT_WIDTH);
    localparam int unsigned TS_LSB    = ts_lsb(ADR_WIDTH, DAT_WIDTH);
    localparam int unsigned OVF_SUM_W = OVF_W + 1;

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [CHANNELS-1:0] hold_v_q, hold_v_d;
    logic [REC_W-1:0]    hold_rec_q [CHANNELS];
    logic [REC_W-1:0]    hold_rec_d [CHANNELS];
    logic [OVF_W-1:0]    ovf_q, ovf_d;

    logic [CHANNELS-1:0]  grant;
    logic                 arb_found;
    logic                 wr_en;
    logic                 pop;
    logic [REC_W-1:0]     wr_data;
    logic [REC_W-1:0]     new_rec;
    logic [3:0]           drops;
    logic [OVF_SUM_W-1:0] ovf_sum;
    logic                 fifo_valid, fifo_full;
    logic [REC_W-1:0]     fifo_rd_data;
    logic [LVL_W-1:0]     fifo_level;

    assign pop = bus.rd_ack & fifo_valid & ~bus.clear;

    // Lowest occupied channel wins the single FIFO write slot of this edge.
    always_comb begin
        grant     = '0;
        wr_data   = '0;
        arb_found = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (hold_v_q[c] && !arb_found) begin
                grant[c]  = 1'b1;
                wr_data   = hold_rec_q[c];
                arb_found = 1'b1;
            end
        end
        wr_en = arb_found & (~fifo_full | pop) & ~bus.clear;
    end

    always_comb begin
        hold_v_d   = hold_v_q;
        hold_rec_d = hold_rec_q;
        drops      = '0;
        new_rec    = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            new_rec                          = '0;
            new_rec[DAT_WIDTH-1:0]           = bus.ch_dat[c*DAT_WIDTH +: DAT_WIDTH];
            new_rec[ADR_LSB +: ADR_WIDTH]    = bus.ch_adr[c*ADR_WIDTH +: ADR_WIDTH];
            new_rec[WE_LSB]                  = bus.ch_we[c];
            new_rec[CHAN_LSB +: CHAN_W]      = CHAN_W'(c);
            new_rec[TS_LSB +: TS_WIDTH]      = ts_q;
            if (grant[c] && wr_en) hold_v_d[c] = 1'b0;
            if (bus.enable && bus.ch_ack[c]) begin
                // A register drained this edge frees up in time for the new capture.
                if (hold_v_d[c]) begin
                    drops = drops + 4'd1;
                end else begin
                    hold_v_d[c]   = 1'b1;
                    hold_rec_d[c] = new_rec;
                end
            end
        end

        ovf_sum = {1'b0, ovf_q} + OVF_SUM_W'(drops);
        ovf_d   = ovf_sum[OVF_W] ? OVF_MAX : ovf_sum[OVF_W-1:0];
        ts_d    = ts_q + TS_WIDTH'(1);

        if (bus.clear) begin
            hold_v_d = '0;
            ovf_d    = '0;
            ts_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q     <= '0;
            hold_v_q <= '0;
            ovf_q    <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) hold_rec_q[c] <= '0;
        end else begin
            ts_q       <= ts_d;
            hold_v_q   <= hold_v_d;
            ovf_q      <= ovf_d;
            hold_rec_q <= hold_rec_d;
        end
    end

    trace_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (bus.clear),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rd_data),
        .valid_o   (fifo_valid),
        .full_o    (fifo_full),
        .level_o   (fifo_level)
    );

    assign bus.rd_data  = fifo_rd_data;
    assign bus.rd_valid = fifo_valid;
    assign bus.level    = fifo_level;
    assign bus.ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_wb_tracer.sv
// Directed bench for wb_tracer: queue-based reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_wb_tracer;

    localparam int unsigned CH    = 2;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TSW   = 16;
    localparam int unsigned RW    = TSW + 3 + 1 + AW + DW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_tracer_if #(.CHANNELS(CH), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .DEPTH(DEPTH), .TS_WIDTH(TSW)) bus ();

    wb_tracer #(.CHANNELS(CH), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] rec(input logic [TSW-1:0] ts, input logic [2:0] ch,
                                          input logic we, input logic [AW-1:0] adr,
                                          input logic [DW-1:0] dat);
        return {ts, ch, we, adr, dat};
    endfunction

    // Reference model: holding slots, a record queue and a drop counter.
    logic [TSW-1:0] m_ts = '0;
    logic           m_hv [CH];
    logic [RW-1:0]  m_hr [CH];
    logic [RW-1:0]  m_q [$];
    int             m_ovf = 0;
    bit             m_done;
    logic [RW-1:0]  exp_rd;

    always @(posedge clk or posedge reset) begin
        if (reset || bus.clear) begin
            m_ts = '0;
            m_q.delete();
            for (int c = 0; c < CH; c++) m_hv[c] = 1'b0;
            m_ovf = 0;
        end else begin
            if (m_q.size() != 0 && bus.rd_ack) void'(m_q.pop_front());
            m_done = 1'b0;
            for (int c = 0; c < CH; c++) begin
                if (!m_done && m_hv[c]) begin
                    m_done = 1'b1;
                    if (m_q.size() < DEPTH) begin
                        m_q.push_back(m_hr[c]);
                        m_hv[c] = 1'b0;
                    end
                end
            end
            for (int c = 0; c < CH; c++) begin
                if (bus.enable && bus.ch_ack[c]) begin
                    if (m_hv[c]) begin
                        if (m_ovf < 65535) m_ovf++;
                    end else begin
                        m_hv[c] = 1'b1;
                        m_hr[c] = rec(m_ts, 3'(c), bus.ch_we[c], bus.ch_adr[c*AW +: AW],
                                      bus.ch_dat[c*DW +: DW]);
                    end
                end
            end
            m_ts = m_ts + 16'd1;
        end
    end

    always @(negedge clk) begin
        exp_rd = (m_q.size() != 0) ? m_q[0] : '0;
        check("rd_valid", 128'(bus.rd_valid), 128'(m_q.size() != 0));
        check("level",    128'(bus.level),    128'(m_q.size()));
        check("ovf_cnt",  128'(bus.ovf_cnt),  128'(m_ovf));
        check("rd_data",  128'(bus.rd_data),  128'(exp_rd));
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_ch(input int c, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        bus.ch_we[c]           = we;
        bus.ch_adr[c*AW +: AW] = adr;
        bus.ch_dat[c*DW +: DW] = dat;
    endtask

    initial begin
        reset = 1'b1;
        bus.enable = 1'b1;
        bus.clear  = 1'b0;
        bus.ch_ack = '0;
        bus.ch_we  = '0;
        bus.ch_adr = '0;
        bus.ch_dat = '0;
        bus.rd_ack = 1'b0;
        repeat (2) cyc();
        check("reset rd_valid", 128'(bus.rd_valid), 128'(0));
        check("reset level",    128'(bus.level),    128'(0));
        check("reset rd_data",  128'(bus.rd_data),  128'(0));
        reset = 1'b0;

        // Single ack captured at ts=5, visible two edges later
        repeat (5) cyc();
        set_ch(0, 1'b1, 32'h100, 32'hDEADBEEF);
        bus.ch_ack = 2'b01;
        cyc();
        bus.ch_ack = 2'b00;
        cyc();
        check("single rd_valid", 128'(bus.rd_valid), 128'(1));
        check("single level",    128'(bus.level),    128'(1));
        check("single rd_data",  128'(bus.rd_data),  128'(rec(16'd5, 3'd0, 1'b1, 32'h100, 32'hDEADBEEF)));
        bus.rd_ack = 1'b1;
        cyc();
        bus.rd_ack = 1'b0;

        // Both channels ack on one edge (ts=8): ch0 first, ch1 second
        set_ch(0, 1'b0, 32'h200, 32'hA0);
        set_ch(1, 1'b1, 32'h300, 32'hB1);
        bus.ch_ack = 2'b11;
        cyc();
        bus.ch_ack = 2'b00;
        repeat (2) cyc();
        check("dual level", 128'(bus.level), 128'(2));
        check("dual first", 128'(bus.rd_data), 128'(rec(16'd8, 3'd0, 1'b0, 32'h200, 32'hA0)));
        bus.rd_ack = 1'b1;
        cyc();
        bus.rd_ack = 1'b0;
        check("dual second", 128'(bus.rd_data), 128'(rec(16'd8, 3'd1, 1'b1, 32'h300, 32'hB1)));
        bus.rd_ack = 1'b1;
        cyc();
        bus.rd_ack = 1'b0;
        check("dual ovf", 128'(bus.ovf_cnt), 128'(0));

        // DEPTH+3 back-to-back ch1 acks without reads
        for (int i = 0; i < DEPTH + 3; i++) begin
            set_ch(1, 1'b0, 32'(32'h1000 + i), 32'(i));
            bus.ch_ack = 2'b10;
            cyc();
        end
        bus.ch_ack = 2'b00;
        cyc();
        check("burst level", 128'(bus.level),   128'(16));
        check("burst ovf",   128'(bus.ovf_cnt), 128'(2));
        bus.rd_ack = 1'b1;
        cyc();
        bus.rd_ack = 1'b0;
        check("burst refill level", 128'(bus.level), 128'(16));
        check("burst head dat", 128'(bus.rd_data[DW-1:0]), 128'(1));

        // Full FIFO: pop and held write on the same edge
        set_ch(0, 1'b1, 32'h2000, 32'hC0);
        bus.ch_ack = 2'b01;
        cyc();
        bus.ch_ack = 2'b00;
        cyc();
        check("full blocked level", 128'(bus.level), 128'(16));
        bus.rd_ack = 1'b1;
        cyc();
        bus.rd_ack = 1'b0;
        check("full swap level", 128'(bus.level), 128'(16));
        for (int i = 0; i < 16; i++) begin
            check("full order dat", 128'(bus.rd_data[DW-1:0]), (i < 15) ? 128'(i + 2) : 128'(32'hC0));
            bus.rd_ack = 1'b1;
            cyc();
        end
        bus.rd_ack = 1'b0;
        check("drained level", 128'(bus.level), 128'(0));

        // Build level=7, ovf=3, then clear (ch1 ack on the clear edge is discarded)
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_ch(0, 1'b0, 32'(32'h4000 + i), 32'(32'h40 + i));
            set_ch(1, 1'b1, 32'(32'h5000 + i), 32'(32'h50 + i));
            bus.ch_ack = (i < 4) ? 2'b11 : 2'b01;
            cyc();
        end
        bus.ch_ack = 2'b00;
        repeat (3) cyc();
        check("preclear level", 128'(bus.level),   128'(7));
        check("preclear ovf",   128'(bus.ovf_cnt), 128'(3));
        bus.clear  = 1'b1;
        bus.ch_ack = 2'b10;
        cyc();
        bus.clear  = 1'b0;
        set_ch(0, 1'b0, 32'h3000, 32'hE0);
        bus.ch_ack = 2'b01;
        check("clear level",    128'(bus.level),    128'(0));
        check("clear rd_valid", 128'(bus.rd_valid), 128'(0));
        check("clear ovf",      128'(bus.ovf_cnt),  128'(0));
        cyc();
        bus.ch_ack = 2'b00;
        cyc();
        check("clear ts zero", 128'(bus.rd_data), 128'(rec(16'd0, 3'd0, 1'b0, 32'h3000, 32'hE0)));
        check("clear one rec", 128'(bus.level), 128'(1));
        bus.rd_ack = 1'b1;
        cyc();
        bus.rd_ack = 1'b0;

        // Held record still drains after enable drops; new acks ignored
        set_ch(0, 1'b1, 32'h6000, 32'h60);
        bus.ch_ack = 2'b01;
        cyc();
        bus.enable = 1'b0;
        set_ch(0, 1'b1, 32'h6001, 32'h61);
        repeat (3) cyc();
        check("disabled level", 128'(bus.level), 128'(1));
        check("disabled head",  128'(bus.rd_data[DW-1:0]), 128'(32'h60));
        bus.ch_ack = 2'b00;
        bus.enable = 1'b1;
        bus.rd_ack = 1'b1;
        cyc();
        bus.rd_ack = 1'b0;

        // Reset mid-burst, then acks with enable low
        for (int i = 0; i < 5; i++) begin
            set_ch(0, 1'b0, 32'(32'h7000 + i), 32'(32'h70 + i));
            bus.ch_ack = 2'b01;
            cyc();
        end
        #2 reset = 1'b1;
        #1;
        check("async rd_valid", 128'(bus.rd_valid), 128'(0));
        check("async level",    128'(bus.level),    128'(0));
        check("async ovf",      128'(bus.ovf_cnt),  128'(0));
        check("async rd_data",  128'(bus.rd_data),  128'(0));
        bus.enable = 1'b0;
        bus.ch_ack = 2'b11;
        repeat (2) cyc();
        reset = 1'b0;
        repeat (5) cyc();
        check("post reset level", 128'(bus.level),    128'(0));
        check("post reset valid", 128'(bus.rd_valid), 128'(0));
        bus.ch_ack = 2'b00;
        bus.enable = 1'b1;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/wb_tracer.md
WB_TRACER -- requirements
Module: wb_tracer

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of monitored Wishbone masters (1..8).
REQ-002 SHALL have parameter ADR_WIDTH, default 32, address width per channel.
REQ-003 SHALL have parameter DAT_WIDTH, default 32, data width per channel.
REQ-004 SHALL have parameter DEPTH, default 16, trace FIFO entries (power of two, >=2).
REQ-005 SHALL have parameter TS_WIDTH, default 16, timestamp width.
REQ-006 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port enable  in  1  capture enable; 0 ignores all acks.
REQ-009 SHALL have port clear  in  1  synchronous flush of FIFO, holding regs, timestamp, overflow count.
REQ-010 SHALL have port ch_ack  in  CHANNELS  per-channel transaction-complete strobe.
REQ-011 SHALL have port ch_we  in  CHANNELS  per-channel write flag.
REQ-012 SHALL have port ch_adr  in  CHANNELS*ADR_WIDTH  packed addresses, channel 0 in LSBs.
REQ-013 SHALL have port ch_dat  in  CHANNELS*DAT_WIDTH  packed data (dat_w if we, else dat_r), channel 0 in LSBs.
REQ-014 SHALL have port rd_data  out  TS_WIDTH+3+1+ADR_WIDTH+DAT_WIDTH  head record {ts, chan[2:0], we, adr, dat}.
REQ-015 SHALL have port rd_valid  out  1  FIFO non-empty.
REQ-016 SHALL have port rd_ack  in  1  pop head when rd_valid.
REQ-017 SHALL have port level  out  clog2(DEPTH)+1  FIFO occupancy.
REQ-018 SHALL have port ovf_cnt  out  16  saturating count of dropped transactions.

Function
REQ-019 SHALL run free-running timestamp counter, +1 per cycle, wrapping 2^TS_WIDTH-1 -> 0.
REQ-020 SHALL, per channel, capture {ts, chan, we, adr, dat} into one-entry holding register on edge where enable=1 and ch_ack=1.
REQ-021 SHALL drop capture and increment ovf_cnt when that channel's holding register is still occupied and not being drained that same edge.
REQ-022 SHALL saturate ovf_cnt at 16'hFFFF; multiple drops on one edge add their count, saturating.
REQ-023 SHALL each edge move at most one occupied holding register into FIFO, fixed priority lowest channel index first.
REQ-024 SHALL permit FIFO write when level<DEPTH or when pop occurs same edge; otherwise holding registers retain contents.
REQ-025 SHALL give latency: ack sampled edge k, uncontended -> FIFO write edge k+1, rd_valid high after edge k+1.
REQ-026 SHALL present head record on rd_data whenever rd_valid=1; rd_data undefined-but-stable-on-reset (zero) when empty.
REQ-027 SHALL pop on edge where rd_valid=1 and rd_ack=1; rd_ack with rd_valid=0 ignored.
REQ-028 SHALL on simultaneous write and pop keep level unchanged, including at level=DEPTH.
REQ-029 SHALL wrap read/write pointers modulo DEPTH.
REQ-030 SHALL on clear=1 (priority over all other activity) zero level, pointers, holding valid bits, timestamp, ovf_cnt; acks that edge discarded.
REQ-031 SHALL capture nothing while enable=0 but continue draining holding registers and serving reads.

Reset
REQ-032 SHALL on reset=1 asynchronously force rd_valid=0, level=0, ovf_cnt=0, rd_data=0, timestamp=0, all holding valid bits=0, pointers=0.
REQ-033 SHALL discard in-flight holding-register contents on reset mid-operation; FIFO RAM contents need not be cleared.

Structure
REQ-034 SHALL place record-field widths/offsets and chan-field width (3) as constants in shared package wb_tracer_pkg.
REQ-035 SHALL instantiate one sub-module trace_fifo (parametrised width/depth, synchronous write, registered pointers, level output).
REQ-036 SHALL keep holding registers and priority arbiter in wb_tracer top level.

Verification
REQ-037 SHALL test single ack ch0 adr=0x100 we=1 dat=0xDEADBEEF at ts=5 -> rd_valid 2 edges later, rd_data={5,0,1,0x100,0xDEADBEEF}, level=1.
REQ-038 SHALL test ch0 and ch1 ack same edge -> ch0 record popped first, ch1 second, identical ts, ovf_cnt=0.
REQ-039 SHALL test DEPTH+3 acks ch1 every cycle, no reads -> level=16, ovf_cnt=2, ch1 held entry written after first rd_ack.
REQ-040 SHALL test full FIFO with rd_ack and new write same edge -> level stays 16, order preserved.
REQ-041 SHALL test clear asserted with level=7, ovf_cnt=3 -> next cycle level=0, rd_valid=0, ovf_cnt=0, ts=0.
REQ-042 SHALL test reset asserted mid-burst, with enable=0 acks afterwards -> all outputs zero immediately, no records captured.
